student_rlight_seq: RTL and testbench

Autonomous sequencer for the running-light peripheral. It holds a small program of light "scenes", each a pattern, a mode, a delay and a hold time. It plays the program by issuing TL-UL PutFullData writes to the rlight registers (REGC delay, REGB mode, REGA pattern), then waits the scene's hold time before moving to the next scene. It sits on the TL-UL crossbar as a host, in parallel with the CPU, and is loaded through a simple local program port.

---
 rtl/student_rlight_seq_pkg.sv | 32 +++
 rtl/tlul_pkg.sv | 45 ++++
 rtl/student_tlul_put_host.sv | 84 ++++++++
 rtl/student_rlight_seq.sv | 219 +++++++++++++++++++++
 tb/tb_student_rlight_seq.sv | 313 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/student_rlight_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : student_rlight_seq_pkg
// Brief    : Scene entry layout, rlight register offsets and sequencer states.
// Revision : 1.0
// ============================================================================
package student_rlight_seq_pkg;

    typedef struct packed {
        logic [15:0] hold;
        logic [7:0]  delay;
        logic [1:0]  mode;
        logic [7:0]  pattern;
    } entry_t;

    localparam logic [31:0] REGA_OFS = 32'h0000_0000;
    localparam logic [31:0] REGB_OFS = 32'h0000_0004;
    localparam logic [31:0] REGC_OFS = 32'h0000_0008;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ_C = 3'd1,
        RSP_C = 3'd2,
        REQ_B = 3'd3,
        RSP_B = 3'd4,
        REQ_A = 3'd5,
        RSP_A = 3'd6,
        HOLD  = 3'd7
    } seq_state_e;

endpackage
`default_nettype wire

// File: rtl/tlul_pkg.sv
`default_nettype none
// ============================================================================
// Module   : tlul_pkg
// Brief    : TL-UL channel A/D types shared by hosts and devices on the crossbar.
// Revision : 1.0
// ============================================================================
package tlul_pkg;

    typedef enum logic [2:0] {
        PutFullData    = 3'h0,
        PutPartialData = 3'h1,
        Get            = 3'h4
    } tl_a_op_e;

    typedef enum logic [2:0] {
        AccessAck     = 3'h0,
        AccessAckData = 3'h1
    } tl_d_op_e;

    typedef struct packed {
        logic        a_valid;
        tl_a_op_e    a_opcode;
        logic [2:0]  a_param;
        logic [1:0]  a_size;
        logic [7:0]  a_source;
        logic [31:0] a_address;
        logic [3:0]  a_mask;
        logic [31:0] a_data;
        logic        d_ready;
    } tl_h2d_t;

    typedef struct packed {
        logic        d_valid;
        tl_d_op_e    d_opcode;
        logic [2:0]  d_param;
        logic [1:0]  d_size;
        logic [7:0]  d_source;
        logic        d_sink;
        logic [31:0] d_data;
        logic        d_error;
        logic        a_ready;
    } tl_d2h_t;

endpackage
`default_nettype wire

// File: rtl/student_tlul_put_host.sv
`default_nettype none
// ============================================================================
// Module   : student_tlul_put_host
// Brief    : Single-outstanding TL-UL PutFullData engine; req_i loads a write.
// Revision : 1.0
// ============================================================================
module student_tlul_put_host #(
    parameter logic [7:0] SourceId = 8'h00
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               req_i,
    input  logic [31:0]        addr_i,
    input  logic [31:0]        data_i,
    output logic               sent_o,
    output logic               ack_o,
    output logic               err_o,
    output tlul_pkg::tl_h2d_t  tl_o,
    input  tlul_pkg::tl_d2h_t  tl_i
);
    import tlul_pkg::*;

    logic        a_valid_q, a_valid_d;
    logic        pend_q, pend_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] data_q, data_d;
    logic        unused_rsp;

    assign sent_o = a_valid_q & tl_i.a_ready;
    assign ack_o  = pend_q & tl_i.d_valid;
    assign err_o  = ack_o & tl_i.d_error;

    // req_i may arrive in the same cycle the previous response retires.
    always_comb begin
        a_valid_d = a_valid_q;
        pend_d    = pend_q;
        addr_d    = addr_q;
        data_d    = data_q;
        if (sent_o) begin
            a_valid_d = 1'b0;
            pend_d    = 1'b1;
        end
        if (ack_o) begin
            pend_d = 1'b0;
        end
        if (req_i) begin
            a_valid_d = 1'b1;
            addr_d    = addr_i;
            data_d    = data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            a_valid_q <= 1'b0;
            pend_q    <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
        end else begin
            a_valid_q <= a_valid_d;
            pend_q    <= pend_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
        end
    end

    always_comb begin
        tl_o           = '0;
        tl_o.a_valid   = a_valid_q;
        tl_o.a_opcode  = PutFullData;
        tl_o.a_param   = 3'h0;
        tl_o.a_size    = 2'd2;
        tl_o.a_source  = SourceId;
        tl_o.a_address = addr_q;
        tl_o.a_mask    = 4'hF;
        tl_o.a_data    = data_q;
        tl_o.d_ready   = 1'b1;
    end

    assign unused_rsp = ^{tl_i.d_opcode, tl_i.d_param, tl_i.d_size,
                          tl_i.d_source, tl_i.d_sink, tl_i.d_data};

endmodule
`default_nettype wire

// File: rtl/student_rlight_seq.sv
`default_nettype none
// ============================================================================
// Module   : student_rlight_seq
// Brief    : Plays a table of light scenes as TL-UL writes to the rlight block.
//            Build macro RLIGHT_SEQ_LOOP_EN: replay the program endlessly.
// Revision : 1.0
// ============================================================================
module student_rlight_seq
    import student_rlight_seq_pkg::*;
#(
    parameter int          NumEntries = 8,
    parameter logic [31:0] RlightBase = 32'h0000_0000,
    parameter logic [7:0]  SourceId   = 8'h00,
    localparam int         IdxW       = $clog2(NumEntries),
    localparam int         LenW       = IdxW + 1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    output tlul_pkg::tl_h2d_t tl_o,
    input  tlul_pkg::tl_d2h_t tl_i,
    input  logic              prog_we_i,
    input  logic [IdxW-1:0]   prog_addr_i,
    input  logic [33:0]       prog_data_i,
    input  logic [LenW-1:0]   len_i,
    input  logic              start_i,
    input  logic              stop_i,
    output logic              busy_o,
    output logic [IdxW-1:0]   idx_o,
    output logic              done_o,
    output logic              err_o
);

    entry_t            table_q [NumEntries];
    entry_t            table_d [NumEntries];
    entry_t            scene_q, scene_d;
    seq_state_e        state_q, state_d;
    logic [IdxW-1:0]   idx_q, idx_d;
    logic [LenW-1:0]   len_q, len_d;
    logic [15:0]       cnt_q, cnt_d;
    logic              busy_q;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              stop_q, stop_d;
    logic              go_scene;
    logic              last_entry;
    logic              stop_now;
    logic              host_req;
    logic [31:0]       host_addr;
    logic [31:0]       host_data;
    logic              host_sent;
    logic              host_ack;
    logic              host_err;

    always_comb begin
        table_d = table_q;
        if (prog_we_i) begin
            table_d[prog_addr_i] = entry_t'(prog_data_i);
        end
    end

    assign last_entry = ({1'b0, idx_q} == (len_q - 1'b1));
    assign stop_now   = stop_q | stop_i;

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        len_d     = len_q;
        scene_d   = scene_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        done_d    = 1'b0;
        stop_d    = stop_now;
        go_scene  = 1'b0;
        host_req  = 1'b0;
        host_addr = '0;
        host_data = '0;

        case (state_q)
            IDLE: begin
                if (start_i && (len_i != '0)) begin
                    len_d    = len_i;
                    idx_d    = '0;
                    err_d    = 1'b0;
                    go_scene = 1'b1;
                end
            end
            REQ_C: if (host_sent) state_d = RSP_C;
            REQ_B: if (host_sent) state_d = RSP_B;
            REQ_A: if (host_sent) state_d = RSP_A;
            RSP_C: begin
                if (host_ack) begin
                    if (host_err) begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end else if (stop_now) begin
                        state_d = IDLE;
                    end else begin
                        host_req  = 1'b1;
                        host_addr = RlightBase + REGB_OFS;
                        host_data = {30'h0, scene_q.mode};
                        state_d   = REQ_B;
                    end
                end
            end
            RSP_B: begin
                if (host_ack) begin
                    if (host_err) begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end else if (stop_now) begin
                        state_d = IDLE;
                    end else begin
                        host_req  = 1'b1;
                        host_addr = RlightBase + REGA_OFS;
                        host_data = {24'h0, scene_q.pattern};
                        state_d   = REQ_A;
                    end
                end
            end
            RSP_A: begin
                if (host_ack) begin
                    if (host_err) begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end else if (stop_now) begin
                        state_d = IDLE;
                    end else begin
                        cnt_d   = scene_q.hold;
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                if (stop_now) begin
                    state_d = IDLE;
                end else if (cnt_q == 16'h0) begin
                    if (last_entry) begin
`ifdef RLIGHT_SEQ_LOOP_EN
                        idx_d    = '0;
                        go_scene = 1'b1;
`else
                        state_d  = IDLE;
                        done_d   = 1'b1;
`endif
                    end else begin
                        idx_d    = idx_q + 1'b1;
                        go_scene = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - 16'h1;
                end
            end
            default: state_d = IDLE;
        endcase

        // The scene is captured from the table only when REQ_C is entered.
        if (go_scene) begin
            scene_d   = table_q[idx_d];
            host_req  = 1'b1;
            host_addr = RlightBase + REGC_OFS;
            host_data = {24'h0, scene_d.delay};
            state_d   = REQ_C;
        end

        if (state_d == IDLE) begin
            stop_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NumEntries; i++) begin
                table_q[i] <= '0;
            end
            scene_q <= '0;
            state_q <= IDLE;
            idx_q   <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            stop_q  <= 1'b0;
        end else begin
            table_q <= table_d;
            scene_q <= scene_d;
            state_q <= state_d;
            idx_q   <= idx_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            busy_q  <= (state_d != IDLE);
            done_q  <= done_d;
            err_q   <= err_d;
            stop_q  <= stop_d;
        end
    end

    assign busy_o = busy_q;
    assign idx_o  = idx_q;
    assign done_o = done_q;
    assign err_o  = err_q;

    student_tlul_put_host #(
        .SourceId (SourceId)
    ) u_put_host (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .req_i  (host_req),
        .addr_i (host_addr),
        .data_i (host_data),
        .sent_o (host_sent),
        .ack_o  (host_ack),
        .err_o  (host_err),
        .tl_o   (tl_o),
        .tl_i   (tl_i)
    );

endmodule
`default_nettype wire

// File: tb/tb_student_rlight_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_student_rlight_seq
// Brief    : Directed bench for student_rlight_seq against a simple TL-UL device.
//            Build macro RLIGHT_SEQ_LOOP_EN selects the looping scenario.
// Revision : 1.0
// ============================================================================
module tb_student_rlight_seq;
    import tlul_pkg::*;

    localparam int          NumEntries = 8;
    localparam logic [31:0] Base       = 32'h4000_1000;
    localparam logic [7:0]  Src        = 8'h5A;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    tl_h2d_t     tl_o;
    tl_d2h_t     tl_i;
    logic        prog_we_i = 1'b0;
    logic [2:0]  prog_addr_i = '0;
    logic [33:0] prog_data_i = '0;
    logic [3:0]  len_i = '0;
    logic        start_i = 1'b0;
    logic        stop_i = 1'b0;
    logic        busy_o;
    logic [2:0]  idx_o;
    logic        done_o;
    logic        err_o;

    always #5 clk_i = ~clk_i;

    student_rlight_seq #(
        .NumEntries (NumEntries),
        .RlightBase (Base),
        .SourceId   (Src)
    ) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .tl_o        (tl_o),
        .tl_i        (tl_i),
        .prog_we_i   (prog_we_i),
        .prog_addr_i (prog_addr_i),
        .prog_data_i (prog_data_i),
        .len_i       (len_i),
        .start_i     (start_i),
        .stop_i      (stop_i),
        .busy_o      (busy_o),
        .idx_o       (idx_o),
        .done_o      (done_o),
        .err_o       (err_o)
    );

    // Device: a_ready low for stall_cfg cycles per request, response next cycle.
    int          stall_cfg = 0;
    int          stall_cnt = 0;
    logic        err_en = 1'b0;
    logic [31:0] err_addr = '0;
    logic        dev_d_valid = 1'b0;
    logic        dev_d_error = 1'b0;
    int          cyc = 0;
    logic [31:0] wr_addr [256];
    logic [31:0] wr_data [256];
    logic [16:0] wr_meta [256];
    int          wr_cyc  [256];
    int          wr_n = 0;

    always_comb begin
        tl_i         = '0;
        tl_i.a_ready = (stall_cnt >= stall_cfg);
        tl_i.d_valid = dev_d_valid;
        tl_i.d_error = dev_d_error;
        tl_i.d_size  = 2'd2;
        tl_i.d_source = Src;
    end

    always @(posedge clk_i) begin
        cyc         <= cyc + 1;
        dev_d_valid <= 1'b0;
        dev_d_error <= 1'b0;
        if (tl_o.a_valid && tl_i.a_ready) begin
            if (wr_n < 256) begin
                wr_addr[wr_n] <= tl_o.a_address;
                wr_data[wr_n] <= tl_o.a_data;
                wr_meta[wr_n] <= {tl_o.a_opcode, tl_o.a_size, tl_o.a_mask, tl_o.a_source};
                wr_cyc[wr_n]  <= cyc;
                wr_n          <= wr_n + 1;
            end
            stall_cnt   <= 0;
            dev_d_valid <= 1'b1;
            dev_d_error <= err_en && (tl_o.a_address == err_addr);
        end else if (tl_o.a_valid) begin
            stall_cnt <= stall_cnt + 1;
        end
    end

    int         done_cnt = 0;
    int         done_cyc = 0;
    logic       done_busy = 1'b1;
    logic [2:0] idx_log [64];
    int         idx_n = 0;

    always @(negedge clk_i) begin
        if (done_o) begin
            done_cnt  = done_cnt + 1;
            done_cyc  = cyc;
            done_busy = busy_o;
        end
        if (tl_o.a_valid && tl_i.a_ready && (tl_o.a_address == Base + 32'h8) && idx_n < 64) begin
            idx_log[idx_n] = idx_o;
            idx_n = idx_n + 1;
        end
    end

    int n_checks = 0;
    int n_fails  = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    int start_cyc = 0;

    task automatic prog_write(input logic [2:0] a, input logic [15:0] hold,
                              input logic [7:0] dly, input logic [1:0] md, input logic [7:0] pat);
        @(negedge clk_i);
        prog_we_i   = 1'b1;
        prog_addr_i = a;
        prog_data_i = {hold, dly, md, pat};
        @(negedge clk_i);
        prog_we_i   = 1'b0;
    endtask

    task automatic do_start(input logic [3:0] len);
        @(negedge clk_i);
        start_cyc = cyc;
        len_i     = len;
        start_i   = 1'b1;
        @(negedge clk_i);
        start_i   = 1'b0;
    endtask

    task automatic wait_idle(input int maxc);
        int n;
        n = 0;
        @(negedge clk_i);
        while (busy_o === 1'b1 && n < maxc) begin
            @(negedge clk_i);
            n++;
        end
        check_eq("idle_within_bound", {31'h0, busy_o}, 32'h0);
        @(negedge clk_i);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_busy"},   {31'h0, busy_o},       32'h0);
        check_eq({tag, "_idx"},    {29'h0, idx_o},        32'h0);
        check_eq({tag, "_done"},   {31'h0, done_o},       32'h0);
        check_eq({tag, "_err"},    {31'h0, err_o},        32'h0);
        check_eq({tag, "_avalid"}, {31'h0, tl_o.a_valid}, 32'h0);
    endtask

    logic [31:0] exp_ofs [6] = '{32'h8, 32'h4, 32'h0, 32'h8, 32'h4, 32'h0};
    logic [31:0] exp_dat [6] = '{32'h3, 32'h1, 32'hA5, 32'h7, 32'h2, 32'h0F};

    initial begin
        int b;
        int d0;
        int i0;
        int n;

        repeat (3) @(negedge clk_i);
        check_reset_outputs("reset");
        rst_ni = 1'b1;
        @(negedge clk_i);

        prog_write(3'd0, 16'd5, 8'd3, 2'd1, 8'hA5);
        prog_write(3'd1, 16'd0, 8'd7, 2'd2, 8'h0F);

`ifdef RLIGHT_SEQ_LOOP_EN
        b  = wr_n;
        d0 = done_cnt;
        i0 = idx_n;
        do_start(4'd2);
        n = 0;
        while (idx_n < i0 + 4 && n < 300) begin
            @(negedge clk_i);
            n++;
        end
        check_eq("loop_four_passes", {31'h0, idx_n >= i0 + 4}, 32'h1);
        stop_i = 1'b1;
        @(negedge clk_i);
        stop_i = 1'b0;
        wait_idle(100);
        check_eq("loop_idx0", {29'h0, idx_log[i0]},     32'h0);
        check_eq("loop_idx1", {29'h0, idx_log[i0 + 1]}, 32'h1);
        check_eq("loop_idx2", {29'h0, idx_log[i0 + 2]}, 32'h0);
        check_eq("loop_idx3", {29'h0, idx_log[i0 + 3]}, 32'h1);
        for (int k = 0; k < 9; k++) begin
            check_eq($sformatf("loop_addr%0d", k), wr_addr[b + k], Base + exp_ofs[k % 6]);
            check_eq($sformatf("loop_data%0d", k), wr_data[b + k], exp_dat[k % 6]);
        end
        check_eq("loop_no_done", done_cnt - d0, 32'h0);
`else
        // Two-scene program, zero-wait device.
        b  = wr_n;
        d0 = done_cnt;
        i0 = idx_n;
        do_start(4'd2);
        wait_idle(200);
        check_eq("play_nwrites", wr_n - b, 32'd6);
        for (int k = 0; k < 6; k++) begin
            check_eq($sformatf("play_addr%0d", k), wr_addr[b + k], Base + exp_ofs[k]);
            check_eq($sformatf("play_data%0d", k), wr_data[b + k], exp_dat[k]);
        end
        check_eq("play_meta", {15'h0, wr_meta[b]}, {15'h0, 3'h0, 2'd2, 4'hF, Src});
        check_eq("play_first_latency", wr_cyc[b] - start_cyc, 32'd1);
        check_eq("play_gap_cb0", wr_cyc[b + 1] - wr_cyc[b],     32'd2);
        check_eq("play_gap_ba0", wr_cyc[b + 2] - wr_cyc[b + 1], 32'd2);
        check_eq("play_hold5",   wr_cyc[b + 3] - wr_cyc[b + 2], 32'd8);
        check_eq("play_gap_cb1", wr_cyc[b + 4] - wr_cyc[b + 3], 32'd2);
        check_eq("play_gap_ba1", wr_cyc[b + 5] - wr_cyc[b + 4], 32'd2);
        check_eq("play_done_cnt", done_cnt - d0, 32'd1);
        check_eq("play_done_time", done_cyc - wr_cyc[b + 5], 32'd3);
        check_eq("play_done_busy", {31'h0, done_busy}, 32'h0);
        check_eq("play_idx0", {29'h0, idx_log[i0]},     32'h0);
        check_eq("play_idx1", {29'h0, idx_log[i0 + 1]}, 32'h1);

        // a_ready held low for four cycles on every request.
        stall_cfg = 4;
        b  = wr_n;
        d0 = done_cnt;
        do_start(4'd1);
        for (int k = 0; k < 5; k++) begin
            check_eq($sformatf("stall_valid%0d", k), {31'h0, tl_o.a_valid}, 32'h1);
            check_eq($sformatf("stall_addr%0d", k),  tl_o.a_address, Base + 32'h8);
            check_eq($sformatf("stall_data%0d", k),  tl_o.a_data, 32'h3);
            @(negedge clk_i);
        end
        wait_idle(200);
        check_eq("stall_nwrites", wr_n - b, 32'd3);
        check_eq("stall_latency", wr_cyc[b] - start_cyc, 32'd5);
        check_eq("stall_addr1", wr_addr[b + 1], Base + 32'h4);
        check_eq("stall_done", done_cnt - d0, 32'd1);

        // Error response on the REGB write.
        stall_cfg = 0;
        err_en    = 1'b1;
        err_addr  = Base + 32'h4;
        b  = wr_n;
        d0 = done_cnt;
        do_start(4'd2);
        wait_idle(100);
        err_en = 1'b0;
        check_eq("err_flag", {31'h0, err_o}, 32'h1);
        check_eq("err_busy", {31'h0, busy_o}, 32'h0);
        check_eq("err_nwrites", wr_n - b, 32'd2);
        check_eq("err_no_done", done_cnt - d0, 32'h0);
        do_start(4'd1);
        check_eq("err_cleared", {31'h0, err_o}, 32'h0);
        wait_idle(100);
        check_eq("err_restart_done", done_cnt - d0, 32'd1);

        // stop_i while a request waits for a_ready.
        stall_cfg = 4;
        b  = wr_n;
        d0 = done_cnt;
        do_start(4'd2);
        stop_i = 1'b1;
        @(negedge clk_i);
        stop_i = 1'b0;
        wait_idle(100);
        check_eq("stop_nwrites", wr_n - b, 32'd1);
        check_eq("stop_latency", wr_cyc[b] - start_cyc, 32'd5);
        check_eq("stop_no_done", done_cnt - d0, 32'h0);
        check_eq("stop_no_err", {31'h0, err_o}, 32'h0);
        repeat (10) @(negedge clk_i);
        check_eq("stop_quiet", wr_n - b, 32'd1);
        stall_cfg = 0;

        // Reset while holding the second scene.
        prog_write(3'd1, 16'd10, 8'd7, 2'd2, 8'h0F);
        b = wr_n;
        do_start(4'd2);
        n = 0;
        while (wr_n < b + 6 && n < 100) begin
            @(negedge clk_i);
            n++;
        end
        repeat (3) @(negedge clk_i);
        check_eq("hold_busy", {31'h0, busy_o}, 32'h1);
        check_eq("hold_idx", {29'h0, idx_o}, 32'h1);
        #2 rst_ni = 1'b0;
        #1 check_reset_outputs("async_reset");
        @(negedge clk_i);
        rst_ni = 1'b1;
        b = wr_n;
        do_start(4'd0);
        repeat (5) @(negedge clk_i);
        check_eq("len0_busy", {31'h0, busy_o}, 32'h0);
        check_eq("len0_nwrites", wr_n - b, 32'h0);
        check_eq("len0_avalid", {31'h0, tl_o.a_valid}, 32'h0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
        $finish;
    end

endmodule
`default_nettype wire
